// File: rtl/alu_pkg.sv
// Shared ALU definitions.
// Holds the operation encodings used by the operand stage and the ALU, plus
// the default operand and register-address widths.
package alu_pkg;

  localparam int DATA_W_DFLT = 32;
  localparam int REG_AW_DFLT = 5;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLT  = 4'd2,
    ALU_SLTU = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9
  } alu_op_e;

endpackage

// File: rtl/operand_bypass.sv
// Per-source operand selection at capture time.
// Ports:
//   addr     - source register index
//   reg_data - register-file read data for that index
//   wb_valid - writeback bus carries a result this cycle
//   wb_addr  - writeback destination index
//   wb_data  - writeback result
//   data     - selected operand value
// Register 0 always reads as zero; that check wins over the bypass so a
// writeback aimed at register 0 can never leak into an operand.
module operand_bypass
  import alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DFLT,
  parameter int REG_AW = REG_AW_DFLT
) (
  input  logic [REG_AW-1:0] addr,
  input  logic [DATA_W-1:0] reg_data,
  input  logic              wb_valid,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] data
);

  always_comb begin
    data = reg_data;
    if (addr == '0) begin
      data = '0;
    end else if (wb_valid && (wb_addr == addr)) begin
      data = wb_data;
    end
  end

endmodule

// File: rtl/alu_operand_stage.sv
// ALU operand stage: two-entry (main + skid) buffer between decode and ALU.
// Ports:
//   iClk, iRstN                 - clock, asynchronous active-low reset
//   iValid / oReady             - upstream handshake (oReady is registered)
//   iRs1Addr/iRs1Data, iRs2Addr/iRs2Data - register sources
//   iImm, iUseImm               - immediate replaces the rs2 operand
//   iAluOp, iRdAddr             - operation and destination register
//   iWbValid, iWbAddr, iWbData  - writeback bypass bus
//   iFlush                      - drop every held op
//   oValid / iReady             - downstream handshake
//   oDataA, oDataB, oAluOp, oRdAddr - operands presented from the main entry
// Held operands keep listening to the writeback bus so an op that stalls
// here still leaves with the newest register value.
module alu_operand_stage
  import alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DFLT,
  parameter int REG_AW = REG_AW_DFLT
) (
  input  logic              iClk,
  input  logic              iRstN,
  input  logic              iValid,
  output logic              oReady,
  input  logic [REG_AW-1:0] iRs1Addr,
  input  logic [REG_AW-1:0] iRs2Addr,
  input  logic [DATA_W-1:0] iRs1Data,
  input  logic [DATA_W-1:0] iRs2Data,
  input  logic [DATA_W-1:0] iImm,
  input  logic              iUseImm,
  input  logic [3:0]        iAluOp,
  input  logic [REG_AW-1:0] iRdAddr,
  input  logic              iWbValid,
  input  logic [REG_AW-1:0] iWbAddr,
  input  logic [DATA_W-1:0] iWbData,
  input  logic              iFlush,
  output logic              oValid,
  input  logic              iReady,
  output logic [DATA_W-1:0] oDataA,
  output logic [DATA_W-1:0] oDataB,
  output logic [3:0]        oAluOp,
  output logic [REG_AW-1:0] oRdAddr
);

  // Main entry (drives the outputs)
  logic              main_valid_reg;
  logic [DATA_W-1:0] main_a_reg, main_b_reg;
  logic [REG_AW-1:0] main_a_addr_reg, main_b_addr_reg;
  logic [3:0]        main_op_reg;
  logic [REG_AW-1:0] main_rd_reg;

  // Skid entry
  logic              skid_valid_reg;
  logic [DATA_W-1:0] skid_a_reg, skid_b_reg;
  logic [REG_AW-1:0] skid_a_addr_reg, skid_b_addr_reg;
  logic [3:0]        skid_op_reg;
  logic [REG_AW-1:0] skid_rd_reg;

  logic              accept;
  logic              drain;
  logic [DATA_W-1:0] byp_a, byp_b;
  logic [DATA_W-1:0] cap_b;
  logic [REG_AW-1:0] cap_b_addr;
  logic [DATA_W-1:0] main_a_upd, main_b_upd, skid_a_upd, skid_b_upd;

  // Ready depends only on skid occupancy, which is itself a register.
  assign oReady  = ~skid_valid_reg;
  assign oValid  = main_valid_reg;
  assign oDataA  = main_a_reg;
  assign oDataB  = main_b_reg;
  assign oAluOp  = main_op_reg;
  assign oRdAddr = main_rd_reg;

  assign accept = iValid && oReady;
  assign drain  = main_valid_reg && iReady;

  operand_bypass #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_byp_a (
    .addr     (iRs1Addr),
    .reg_data (iRs1Data),
    .wb_valid (iWbValid),
    .wb_addr  (iWbAddr),
    .wb_data  (iWbData),
    .data     (byp_a)
  );

  operand_bypass #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_byp_b (
    .addr     (iRs2Addr),
    .reg_data (iRs2Data),
    .wb_valid (iWbValid),
    .wb_addr  (iWbAddr),
    .wb_data  (iWbData),
    .data     (byp_b)
  );

  // An immediate B operand is stored with address 0 so later writebacks
  // never overwrite it.
  assign cap_b      = iUseImm ? iImm : byp_b;
  assign cap_b_addr = iUseImm ? '0 : iRs2Addr;

  function automatic logic wb_hit(input logic [REG_AW-1:0] a,
                                  input logic              wb_valid,
                                  input logic [REG_AW-1:0] wb_addr);
    return wb_valid && (a != '0) && (a == wb_addr);
  endfunction

  // Writeback snooping for operands already held in either entry.
  always_comb begin
    main_a_upd = main_a_reg;
    main_b_upd = main_b_reg;
    skid_a_upd = skid_a_reg;
    skid_b_upd = skid_b_reg;
    if (wb_hit(main_a_addr_reg, iWbValid, iWbAddr)) main_a_upd = iWbData;
    if (wb_hit(main_b_addr_reg, iWbValid, iWbAddr)) main_b_upd = iWbData;
    if (wb_hit(skid_a_addr_reg, iWbValid, iWbAddr)) skid_a_upd = iWbData;
    if (wb_hit(skid_b_addr_reg, iWbValid, iWbAddr)) skid_b_upd = iWbData;
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      main_valid_reg  <= 1'b0;
      main_a_reg      <= '0;
      main_b_reg      <= '0;
      main_a_addr_reg <= '0;
      main_b_addr_reg <= '0;
      main_op_reg     <= '0;
      main_rd_reg     <= '0;
      skid_valid_reg  <= 1'b0;
      skid_a_reg      <= '0;
      skid_b_reg      <= '0;
      skid_a_addr_reg <= '0;
      skid_b_addr_reg <= '0;
      skid_op_reg     <= '0;
      skid_rd_reg     <= '0;
    end else if (iFlush) begin
      // Flush wins over any accept in the same cycle.
      main_valid_reg  <= 1'b0;
      main_a_reg      <= '0;
      main_b_reg      <= '0;
      main_a_addr_reg <= '0;
      main_b_addr_reg <= '0;
      main_op_reg     <= '0;
      main_rd_reg     <= '0;
      skid_valid_reg  <= 1'b0;
      skid_a_reg      <= '0;
      skid_b_reg      <= '0;
      skid_a_addr_reg <= '0;
      skid_b_addr_reg <= '0;
      skid_op_reg     <= '0;
      skid_rd_reg     <= '0;
    end else begin
      // Default: held operands absorb matching writebacks.
      main_a_reg <= main_a_upd;
      main_b_reg <= main_b_upd;
      skid_a_reg <= skid_a_upd;
      skid_b_reg <= skid_b_upd;

      if (!main_valid_reg || drain) begin
        if (skid_valid_reg) begin
          // Skid is older than anything upstream; promote it first.
          // oReady was low, so nothing is accepted this cycle.
          main_valid_reg  <= 1'b1;
          main_a_reg      <= skid_a_upd;
          main_b_reg      <= skid_b_upd;
          main_a_addr_reg <= skid_a_addr_reg;
          main_b_addr_reg <= skid_b_addr_reg;
          main_op_reg     <= skid_op_reg;
          main_rd_reg     <= skid_rd_reg;
          skid_valid_reg  <= 1'b0;
        end else if (accept) begin
          main_valid_reg  <= 1'b1;
          main_a_reg      <= byp_a;
          main_b_reg      <= cap_b;
          main_a_addr_reg <= iRs1Addr;
          main_b_addr_reg <= cap_b_addr;
          main_op_reg     <= iAluOp;
          main_rd_reg     <= iRdAddr;
        end else begin
          main_valid_reg  <= 1'b0;
        end
      end else if (accept) begin
        // Main is stalled: park the new op.
        skid_valid_reg  <= 1'b1;
        skid_a_reg      <= byp_a;
        skid_b_reg      <= cap_b;
        skid_a_addr_reg <= iRs1Addr;
        skid_b_addr_reg <= cap_b_addr;
        skid_op_reg     <= iAluOp;
        skid_rd_reg     <= iRdAddr;
      end
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
module tb_alu_operand_stage;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in;
  logic        ready_out;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data;
  logic [31:0] imm;
  logic        use_imm;
  logic [3:0]  alu_op;
  logic [4:0]  rd_addr;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        flush;
  logic        valid_out;
  logic        ready_in;
  logic [31:0] data_a, data_b;
  logic [3:0]  op_out;
  logic [4:0]  rd_out;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  alu_operand_stage dut (
    .iClk     (clk),
    .iRstN    (rst_n),
    .iValid   (valid_in),
    .oReady   (ready_out),
    .iRs1Addr (rs1_addr),
    .iRs2Addr (rs2_addr),
    .iRs1Data (rs1_data),
    .iRs2Data (rs2_data),
    .iImm     (imm),
    .iUseImm  (use_imm),
    .iAluOp   (alu_op),
    .iRdAddr  (rd_addr),
    .iWbValid (wb_valid),
    .iWbAddr  (wb_addr),
    .iWbData  (wb_data),
    .iFlush   (flush),
    .oValid   (valid_out),
    .iReady   (ready_in),
    .oDataA   (data_a),
    .oDataB   (data_b),
    .oAluOp   (op_out),
    .oRdAddr  (rd_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
    $display("vec %0d %s observed=%08h expected=%08h", vectors, tag, obs, exp);
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic [4:0] a1, input logic [31:0] d1,
                          input logic [4:0] a2, input logic [31:0] d2,
                          input logic [3:0] op, input logic [4:0] rd);
    valid_in = 1'b1;
    rs1_addr = a1; rs1_data = d1;
    rs2_addr = a2; rs2_data = d2;
    alu_op   = op; rd_addr  = rd;
    use_imm  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    valid_in = 0; rs1_addr = 0; rs2_addr = 0; rs1_data = 0; rs2_data = 0;
    imm = 0; use_imm = 0; alu_op = 0; rd_addr = 0;
    wb_valid = 0; wb_addr = 0; wb_data = 0; flush = 0; ready_in = 1;

    // Reset state
    #2;
    check("rst_valid", 32'(valid_out), 32'd0);
    check("rst_ready", 32'(ready_out), 32'd1);
    check("rst_a",     data_a, 32'd0);
    check("rst_b",     data_b, 32'd0);
    check("rst_op",    32'(op_out), 32'd0);
    check("rst_rd",    32'(rd_out), 32'd0);
    @(posedge clk); #3 rst_n = 1'b1;
    tick();

    // Basic capture, latency 1
    drive_op(5'd3, 32'h5, 5'd4, 32'h7, ALU_SLT, 5'd1);
    tick();
    check("basic_valid", 32'(valid_out), 32'd1);
    check("basic_a",     data_a, 32'h5);
    check("basic_b",     data_b, 32'h7);
    check("basic_op",    32'(op_out), 32'(ALU_SLT));
    check("basic_rd",    32'(rd_out), 32'd1);
    valid_in = 0;
    tick();
    check("basic_drained", 32'(valid_out), 32'd0);

    // Capture-time bypass and register-0 forcing
    drive_op(5'd3, 32'h5, 5'd4, 32'h7, ALU_ADD, 5'd2);
    wb_valid = 1; wb_addr = 5'd3; wb_data = 32'hFFFF_FFFF;
    tick();
    check("byp_a",   data_a, 32'hFFFF_FFFF);
    check("byp_b",   data_b, 32'h7);
    drive_op(5'd0, 32'h55, 5'd4, 32'h7, ALU_ADD, 5'd2);
    wb_valid = 1; wb_addr = 5'd0; wb_data = 32'h99;
    tick();
    check("zero_a",  data_a, 32'h0);
    valid_in = 0; wb_valid = 0;
    tick();

    // Backpressure: two accepted, third held, then in-order drain
    ready_in = 0;
    drive_op(5'd1, 32'h11, 5'd2, 32'h22, ALU_ADD, 5'd5);
    tick();
    check("bp_first_a",  data_a, 32'h11);
    check("bp_ready1",   32'(ready_out), 32'd1);
    drive_op(5'd1, 32'h33, 5'd2, 32'h44, ALU_SUB, 5'd6);
    tick();
    check("bp_ready0",   32'(ready_out), 32'd0);
    check("bp_stable_a", data_a, 32'h11);
    drive_op(5'd1, 32'h55, 5'd2, 32'h66, ALU_XOR, 5'd7);
    tick();
    check("bp_hold_rd",  32'(rd_out), 32'd5);
    check("bp_hold_rdy", 32'(ready_out), 32'd0);
    ready_in = 1;
    tick();
    check("bp_second_a",  data_a, 32'h33);
    check("bp_second_op", 32'(op_out), 32'(ALU_SUB));
    check("bp_second_rd", 32'(rd_out), 32'd6);
    tick();
    check("bp_third_a",   data_a, 32'h55);
    check("bp_third_rd",  32'(rd_out), 32'd7);
    valid_in = 0;
    tick();
    check("bp_empty",     32'(valid_out), 32'd0);

    // Held-operand writeback update, immediate immunity, skid update
    ready_in = 0;
    drive_op(5'd0, 32'hDEAD, 5'd9, 32'h1, ALU_OR, 5'd8);
    tick();
    check("hold_b_init", data_b, 32'h1);
    valid_in = 0;
    wb_valid = 1; wb_addr = 5'd9; wb_data = 32'h1234;
    tick();
    check("hold_b_upd",  data_b, 32'h1234);
    check("hold_a_zero", data_a, 32'h0);
    wb_valid = 0; flush = 1;
    tick();
    flush = 0;
    check("flush1_valid", 32'(valid_out), 32'd0);
    drive_op(5'd0, 32'h0, 5'd9, 32'h1, ALU_ADD, 5'd4);
    use_imm = 1; imm = 32'hCAFE;
    wb_valid = 1; wb_addr = 5'd9; wb_data = 32'h5678;
    tick();
    check("imm_capture", data_b, 32'hCAFE);
    valid_in = 0; use_imm = 0; wb_data = 32'h1234;
    tick();
    check("imm_held",    data_b, 32'hCAFE);
    wb_valid = 0;
    drive_op(5'd9, 32'h1, 5'd0, 32'h0, ALU_AND, 5'd3);
    tick();
    check("skid_full",   32'(ready_out), 32'd0);
    valid_in = 0;
    wb_valid = 1; wb_addr = 5'd9; wb_data = 32'hBEEF;
    tick();
    wb_valid = 0; ready_in = 1;
    tick();
    check("skid_upd_a",  data_a, 32'hBEEF);
    check("skid_upd_rd", 32'(rd_out), 32'd3);
    tick();

    // Flush with both entries full and an op offered
    ready_in = 0;
    drive_op(5'd1, 32'h1, 5'd2, 32'h2, ALU_ADD, 5'd1);
    tick();
    drive_op(5'd1, 32'h3, 5'd2, 32'h4, ALU_ADD, 5'd2);
    tick();
    check("fl_full_rdy", 32'(ready_out), 32'd0);
    drive_op(5'd1, 32'h5, 5'd2, 32'h6, ALU_ADD, 5'd12);
    flush = 1;
    tick();
    flush = 0; valid_in = 0;
    check("fl_valid",    32'(valid_out), 32'd0);
    check("fl_ready",    32'(ready_out), 32'd1);
    tick();
    check("fl_stay",     32'(valid_out), 32'd0);
    // Flush while ready: the offered op must be dropped
    drive_op(5'd1, 32'h7, 5'd2, 32'h8, ALU_ADD, 5'd13);
    flush = 1;
    tick();
    flush = 0; valid_in = 0;
    check("fl_accept_drop", 32'(valid_out), 32'd0);
    check("fl_accept_rd",   32'(rd_out), 32'd0);

    // Asynchronous reset mid-stall
    drive_op(5'd1, 32'hA1, 5'd2, 32'hA2, ALU_ADD, 5'd1);
    tick();
    drive_op(5'd1, 32'hB1, 5'd2, 32'hB2, ALU_ADD, 5'd2);
    tick();
    valid_in = 0;
    check("ar_pre_rdy", 32'(ready_out), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("ar_valid",   32'(valid_out), 32'd0);
    check("ar_ready",   32'(ready_out), 32'd1);
    check("ar_a",       data_a, 32'h0);
    @(posedge clk); #3 rst_n = 1'b1;
    tick();
    check("ar_idle",    32'(valid_out), 32'd0);
    ready_in = 1;
    drive_op(5'd6, 32'h66, 5'd7, 32'h77, ALU_SLTU, 5'd9);
    tick();
    check("ar_first_a",  data_a, 32'h66);
    check("ar_first_op", 32'(op_out), 32'(ALU_SLTU));
    valid_in = 0;
    tick();
    check("ar_done",     32'(valid_out), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
